// File: rtl/mem_pkg.sv
// Shared types and constants for the L1-to-lower-cache arbiter slice.
package mem_pkg;
  localparam int LC_LINE_BITS   = 512;
  localparam int LC_OFFSET_BITS = 6;
  localparam int LC_ADDR_BITS   = 64;

  typedef enum logic {
    SRC_L1I = 1'b0,
    SRC_L1D = 1'b1
  } lc_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } lc_req_state_e;

  // The lower cache only ever sees whole-line addresses.
  function automatic logic [LC_ADDR_BITS-1:0] line_align(input logic [LC_ADDR_BITS-1:0] addr);
    return addr & ~((LC_ADDR_BITS'(1) << LC_OFFSET_BITS) - LC_ADDR_BITS'(1));
  endfunction
endpackage

// File: rtl/lc_arbiter_if.sv
// Bundle of L1I/L1D request, fill and lower-cache handshakes seen by lc_arbiter.
interface lc_arbiter_if
  import mem_pkg::*;
#(
  parameter int LINE_BITS = LC_LINE_BITS
);
  logic                    l1i_valid_in;
  logic [LC_ADDR_BITS-1:0] l1i_addr_in;
  logic                    l1i_ready_out;

  logic                    l1d_valid_in;
  logic [LC_ADDR_BITS-1:0] l1d_addr_in;
  logic [LINE_BITS-1:0]    l1d_value_in;
  logic                    l1d_we_in;
  logic                    l1d_ready_out;

  logic                    l1i_resp_valid_out, l1d_resp_valid_out;
  logic [LC_ADDR_BITS-1:0] l1i_resp_addr_out, l1d_resp_addr_out;
  logic [LINE_BITS-1:0]    l1i_resp_value_out, l1d_resp_value_out;
  logic                    l1i_resp_ready_in, l1d_resp_ready_in;

  logic                    lc_valid_out;
  logic [LC_ADDR_BITS-1:0] lc_addr_out;
  logic [LINE_BITS-1:0]    lc_value_out;
  logic                    lc_we_out;
  logic                    lc_ready_in;

  logic                    lc_valid_in;
  logic [LC_ADDR_BITS-1:0] lc_addr_in;
  logic [LINE_BITS-1:0]    lc_value_in;
  logic                    lc_ready_out;

  modport slave (
    input  l1i_valid_in, l1i_addr_in, l1d_valid_in, l1d_addr_in, l1d_value_in, l1d_we_in,
           l1i_resp_ready_in, l1d_resp_ready_in, lc_ready_in,
           lc_valid_in, lc_addr_in, lc_value_in,
    output l1i_ready_out, l1d_ready_out,
           l1i_resp_valid_out, l1d_resp_valid_out, l1i_resp_addr_out, l1d_resp_addr_out,
           l1i_resp_value_out, l1d_resp_value_out,
           lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out
  );

  modport master (
    output l1i_valid_in, l1i_addr_in, l1d_valid_in, l1d_addr_in, l1d_value_in, l1d_we_in,
           l1i_resp_ready_in, l1d_resp_ready_in, lc_ready_in,
           lc_valid_in, lc_addr_in, lc_value_in,
    input  l1i_ready_out, l1d_ready_out,
           l1i_resp_valid_out, l1d_resp_valid_out, l1i_resp_addr_out, l1d_resp_addr_out,
           l1i_resp_value_out, l1d_resp_value_out,
           lc_valid_out, lc_addr_out, lc_value_out, lc_we_out, lc_ready_out
  );
endinterface

// File: rtl/lc_src_fifo.sv
// In-order tracker of which L1 issued each outstanding read; head is the next fill's owner.
module lc_src_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    push,
  input  lc_src_e push_src,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output lc_src_e head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  lc_src_e          slots_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign head    = slots_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so push-while-full is allowed only alongside a pop.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i] <= SRC_L1I;
    end else begin
      if (do_push) begin
        slots_q[wr_ptr_q] <= push_src;
        wr_ptr_q          <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/lc_arbiter.sv
// Round-robin arbiter merging L1I and L1D misses onto one lower-cache port and routing fills back.
module lc_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_BITS       = LC_LINE_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  lc_arbiter_if.slave bus,
  output logic        err_out
);
  lc_req_state_e state_q, state_d;
  lc_src_e       last_grant_q, push_src, trk_head, resp_src_q;
  logic          grant_i, grant_d, accept, l1i_elig, l1d_elig;
  logic          trk_push, trk_pop, trk_full, trk_empty;

  logic [LC_ADDR_BITS-1:0] req_addr_q, resp_addr_q;
  logic [LINE_BITS-1:0]    req_value_q, resp_value_q;
  logic                    req_we_q, resp_full_q, resp_accept, resp_done, err_q;

  // Eligibility looks at the registered tracker count, so a same-cycle pop never unblocks a read.
  always_comb begin
    state_d  = state_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    l1i_elig = bus.l1i_valid_in && !trk_full;
    l1d_elig = bus.l1d_valid_in && (bus.l1d_we_in || !trk_full);
    case (state_q)
      ST_IDLE: begin
        if (l1i_elig && l1d_elig) begin
          grant_i = (last_grant_q == SRC_L1D);
          grant_d = (last_grant_q == SRC_L1I);
        end else begin
          grant_i = l1i_elig;
          grant_d = l1d_elig;
        end
        if (grant_i || grant_d) state_d = ST_SEND;
      end
      ST_SEND: if (bus.lc_ready_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept            = (grant_i || grant_d) && !rst_in;
  assign bus.l1i_ready_out = grant_i && !rst_in;
  assign bus.l1d_ready_out = grant_d && !rst_in;
  assign push_src          = grant_d ? SRC_L1D : SRC_L1I;
  assign trk_push          = accept && !(grant_d && bus.l1d_we_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant_q <= SRC_L1D;
      req_addr_q   <= '0;
      req_value_q  <= '0;
      req_we_q     <= 1'b0;
    end else if (accept) begin
      last_grant_q <= push_src;
      if (grant_d) begin
        req_addr_q  <= line_align(bus.l1d_addr_in);
        req_value_q <= bus.l1d_value_in;
        req_we_q    <= bus.l1d_we_in;
      end else begin
        req_addr_q  <= line_align(bus.l1i_addr_in);
        req_value_q <= '0;
        req_we_q    <= 1'b0;
      end
    end
  end

  assign bus.lc_valid_out = (state_q == ST_SEND);
  assign bus.lc_addr_out  = req_addr_q;
  assign bus.lc_value_out = req_value_q;
  assign bus.lc_we_out    = req_we_q;

  lc_src_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tracker (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (trk_push),
    .push_src (push_src),
    .pop      (trk_pop),
    .full     (trk_full),
    .empty    (trk_empty),
    .head     (trk_head)
  );

  assign bus.lc_ready_out = !resp_full_q && !rst_in;
  assign resp_accept      = bus.lc_valid_in && bus.lc_ready_out;
  assign resp_done        = resp_full_q && ((resp_src_q == SRC_L1I) ? bus.l1i_resp_ready_in
                                                                    : bus.l1d_resp_ready_in);
  assign trk_pop          = resp_done;

  // A fill with nothing outstanding is swallowed and latched as a protocol error.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_full_q  <= 1'b0;
      resp_src_q   <= SRC_L1I;
      resp_addr_q  <= '0;
      resp_value_q <= '0;
      err_q        <= 1'b0;
    end else begin
      if (resp_done) resp_full_q <= 1'b0;
      if (resp_accept) begin
        if (trk_empty) begin
          err_q <= 1'b1;
        end else begin
          resp_full_q  <= 1'b1;
          resp_src_q   <= trk_head;
          resp_addr_q  <= bus.lc_addr_in;
          resp_value_q <= bus.lc_value_in;
        end
      end
    end
  end

  assign bus.l1i_resp_valid_out = resp_full_q && (resp_src_q == SRC_L1I);
  assign bus.l1d_resp_valid_out = resp_full_q && (resp_src_q == SRC_L1D);
  assign bus.l1i_resp_addr_out  = resp_addr_q;
  assign bus.l1d_resp_addr_out  = resp_addr_q;
  assign bus.l1i_resp_value_out = resp_value_q;
  assign bus.l1d_resp_value_out = resp_value_q;
  assign err_out                = err_q;
endmodule

// File: tb/tb_lc_arbiter.sv
// Scenario tasks plus a randomized run against a queue-based model of the arbiter's rules.
module tb_lc_arbiter;
  localparam int MAX_OUTSTANDING = 4;
  localparam int LINE_BITS       = 512;

  logic clk_in;
  logic rst_in;
  logic err_out;
  int   total;
  int   bad;

  lc_arbiter_if #(.LINE_BITS(LINE_BITS)) bus ();

  lc_arbiter #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .LINE_BITS(LINE_BITS)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .bus     (bus),
    .err_out (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] v;
    for (int i = 0; i < LINE_BITS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.l1i_valid_in      = 1'b0;
    bus.l1i_addr_in       = '0;
    bus.l1d_valid_in      = 1'b0;
    bus.l1d_addr_in       = '0;
    bus.l1d_value_in      = '0;
    bus.l1d_we_in         = 1'b0;
    bus.l1i_resp_ready_in = 1'b0;
    bus.l1d_resp_ready_in = 1'b0;
    bus.lc_ready_in       = 1'b0;
    bus.lc_valid_in       = 1'b0;
    bus.lc_addr_in        = '0;
    bus.lc_value_in       = '0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_in = 1'b1;
    #12;
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b1;
    bus.l1i_valid_in = 1'b1;
    bus.l1d_valid_in = 1'b1;
    bus.lc_valid_in  = 1'b1;
    @(posedge clk_in);
    #2;
    total++; if (bus.l1i_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_l1i_ready got=%0b want=0", bus.l1i_ready_out); end
    total++; if (bus.l1d_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_l1d_ready got=%0b want=0", bus.l1d_ready_out); end
    total++; if (bus.lc_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_lc_ready got=%0b want=0", bus.lc_ready_out); end
    total++; if (bus.lc_valid_out !== 1'b0) begin bad++; $display("[TB] FAIL rst_lc_valid got=%0b want=0", bus.lc_valid_out); end
    total++; if ({bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, err_out} !== 3'b000) begin bad++; $display("[TB] FAIL rst_resp_err got=%b want=000", {bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, err_out}); end
    total++; if (bus.lc_addr_out !== 64'h0) begin bad++; $display("[TB] FAIL rst_lc_addr got=%h want=0", bus.lc_addr_out); end
    reset_dut();
    total++; if (bus.lc_ready_out !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_lc_ready got=%0b want=1", bus.lc_ready_out); end
  endtask

  task automatic test_tie_round_robin();
    reset_dut();
    bus.l1i_valid_in = 1'b1; bus.l1i_addr_in = 64'h1040;
    bus.l1d_valid_in = 1'b1; bus.l1d_addr_in = 64'h2000; bus.l1d_we_in = 1'b0;
    #1;
    total++; if (bus.l1i_ready_out !== 1'b1) begin bad++; $display("[TB] FAIL tie_first_i got=%0b want=1", bus.l1i_ready_out); end
    total++; if (bus.l1d_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL tie_first_d got=%0b want=0", bus.l1d_ready_out); end
    tick();
    bus.l1i_addr_in = 64'h1080;
    #1;
    total++; if (bus.lc_valid_out !== 1'b1 || bus.lc_addr_out !== 64'h1040) begin bad++; $display("[TB] FAIL tie_send_i got=%0b/%h want=1/1040", bus.lc_valid_out, bus.lc_addr_out); end
    total++; if ({bus.l1i_ready_out, bus.l1d_ready_out} !== 2'b00) begin bad++; $display("[TB] FAIL send_readies got=%b want=00", {bus.l1i_ready_out, bus.l1d_ready_out}); end
    tick();
    total++; if (bus.lc_valid_out !== 1'b1 || bus.lc_addr_out !== 64'h1040) begin bad++; $display("[TB] FAIL send_hold got=%0b/%h want=1/1040", bus.lc_valid_out, bus.lc_addr_out); end
    bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
    #1;
    total++; if ({bus.l1i_ready_out, bus.l1d_ready_out} !== 2'b01) begin bad++; $display("[TB] FAIL rr_second_d got=%b want=01", {bus.l1i_ready_out, bus.l1d_ready_out}); end
    tick();
    bus.l1d_valid_in = 1'b0;
    #1;
    total++; if (bus.lc_addr_out !== 64'h2000 || bus.lc_we_out !== 1'b0) begin bad++; $display("[TB] FAIL tie_send_d got=%h/%0b want=2000/0", bus.lc_addr_out, bus.lc_we_out); end
    bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
    bus.l1i_valid_in = 1'b0;
  endtask

  task automatic test_align();
    reset_dut();
    bus.l1i_valid_in = 1'b1; bus.l1i_addr_in = 64'h1047;
    tick();
    bus.l1i_valid_in = 1'b0;
    #1;
    total++; if (bus.lc_addr_out !== 64'h1040) begin bad++; $display("[TB] FAIL align_addr got=%h want=1040", bus.lc_addr_out); end
    total++; if (bus.lc_we_out !== 1'b0 || bus.lc_value_out !== '0) begin bad++; $display("[TB] FAIL align_we_value got we=%0b value_nonzero=%0b want=0/0", bus.lc_we_out, |bus.lc_value_out); end
    bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
  endtask

  task automatic test_tracker_full();
    logic [LINE_BITS-1:0] wb_line;
    reset_dut();
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      bus.l1d_valid_in = 1'b1; bus.l1d_we_in = 1'b0; bus.l1d_addr_in = 64'h3000 + 64'(i * 64);
      #1;
      total++; if (bus.l1d_ready_out !== 1'b1) begin bad++; $display("[TB] FAIL fill_read%0d got=%0b want=1", i, bus.l1d_ready_out); end
      tick();
      bus.l1d_valid_in = 1'b0; bus.lc_ready_in = 1'b1;
      tick();
      bus.lc_ready_in = 1'b0;
    end
    bus.l1i_valid_in = 1'b1; bus.l1i_addr_in = 64'h9000;
    bus.l1d_valid_in = 1'b1; bus.l1d_addr_in = 64'h4008;
    #1;
    total++; if ({bus.l1i_ready_out, bus.l1d_ready_out} !== 2'b00) begin bad++; $display("[TB] FAIL full_reads_blocked got=%b want=00", {bus.l1i_ready_out, bus.l1d_ready_out}); end
    wb_line = rand_line();
    bus.l1d_we_in = 1'b1; bus.l1d_value_in = wb_line;
    #1;
    total++; if ({bus.l1i_ready_out, bus.l1d_ready_out} !== 2'b01) begin bad++; $display("[TB] FAIL full_wb_eligible got=%b want=01", {bus.l1i_ready_out, bus.l1d_ready_out}); end
    tick();
    bus.l1d_valid_in = 1'b0; bus.l1d_we_in = 1'b0;
    #1;
    total++; if (bus.lc_we_out !== 1'b1 || bus.lc_addr_out !== 64'h4000 || bus.lc_value_out !== wb_line) begin bad++; $display("[TB] FAIL wb_fields got we=%0b addr=%h want we=1 addr=4000 with written line", bus.lc_we_out, bus.lc_addr_out); end
    bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'h3000; bus.lc_value_in = rand_line();
    bus.l1d_resp_ready_in = 1'b1;
    #1;
    total++; if (bus.l1i_ready_out !== 1'b0) begin bad++; $display("[TB] FAIL still_full got=%0b want=0", bus.l1i_ready_out); end
    tick();
    bus.lc_valid_in = 1'b0;
    #1;
    total++; if ({bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.l1i_ready_out} !== 3'b010) begin bad++; $display("[TB] FAIL full_pop_cycle got=%b want=010", {bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.l1i_ready_out}); end
    tick();
    total++; if ({bus.l1d_resp_valid_out, bus.l1i_ready_out} !== 2'b01) begin bad++; $display("[TB] FAIL after_pop got=%b want=01", {bus.l1d_resp_valid_out, bus.l1i_ready_out}); end
    idle_inputs();
  endtask

  task automatic test_response_routing();
    logic [LINE_BITS-1:0] a_line, b_line;
    reset_dut();
    a_line = rand_line();
    b_line = rand_line();
    bus.l1i_valid_in = 1'b1; bus.l1i_addr_in = 64'h5000;
    tick();
    bus.l1i_valid_in = 1'b0; bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0; bus.l1d_valid_in = 1'b1; bus.l1d_addr_in = 64'h6000;
    tick();
    bus.l1d_valid_in = 1'b0; bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'hA000; bus.lc_value_in = a_line;
    tick();
    bus.lc_addr_in = 64'hB000; bus.lc_value_in = b_line; bus.l1i_resp_ready_in = 1'b1;
    #1;
    total++; if ({bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out} !== 3'b100) begin bad++; $display("[TB] FAIL route_first_flags got=%b want=100", {bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out}); end
    total++; if (bus.l1i_resp_addr_out !== 64'hA000 || bus.l1i_resp_value_out !== a_line) begin bad++; $display("[TB] FAIL route_first_data got addr=%h want=a000", bus.l1i_resp_addr_out); end
    tick();
    bus.l1i_resp_ready_in = 1'b0;
    tick();
    bus.lc_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if ({bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out} !== 3'b010 || bus.l1d_resp_addr_out !== 64'hB000) begin bad++; $display("[TB] FAIL route_second_hold%0d got=%b addr=%h want=010 addr=b000", i, {bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out}, bus.l1d_resp_addr_out); end
      tick();
    end
    bus.l1d_resp_ready_in = 1'b1;
    total++; if (bus.l1d_resp_value_out !== b_line) begin bad++; $display("[TB] FAIL route_second_value got=%h", bus.l1d_resp_value_out[31:0]); end
    tick();
    total++; if ({bus.l1d_resp_valid_out, bus.lc_ready_out} !== 2'b01) begin bad++; $display("[TB] FAIL route_drained got=%b want=01", {bus.l1d_resp_valid_out, bus.lc_ready_out}); end
    idle_inputs();
  endtask

  task automatic test_orphan_response();
    reset_dut();
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'hC000; bus.lc_value_in = rand_line();
    #1;
    total++; if (bus.lc_ready_out !== 1'b1) begin bad++; $display("[TB] FAIL orphan_ready got=%0b want=1", bus.lc_ready_out); end
    tick();
    bus.lc_valid_in = 1'b0;
    total++; if ({err_out, bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out} !== 4'b1001) begin bad++; $display("[TB] FAIL orphan_drop got=%b want=1001", {err_out, bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, bus.lc_ready_out}); end
    repeat (3) tick();
    total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%0b want=1", err_out); end
    rst_in = 1'b1;
    #1;
    total++; if (err_out !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared got=%0b want=0", err_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    reset_dut();
    bus.l1d_valid_in = 1'b1; bus.l1d_addr_in = 64'h7010; bus.l1d_we_in = 1'b0;
    tick();
    total++; if (bus.lc_valid_out !== 1'b1 || bus.lc_addr_out !== 64'h7000) begin bad++; $display("[TB] FAIL mid_send_before got=%0b/%h want=1/7000", bus.lc_valid_out, bus.lc_addr_out); end
    #1;
    rst_in = 1'b1;
    #1;
    total++; if ({bus.lc_valid_out, bus.l1d_ready_out} !== 2'b00 || bus.lc_addr_out !== 64'h0) begin bad++; $display("[TB] FAIL mid_send_async got=%b addr=%h want=00 addr=0", {bus.lc_valid_out, bus.l1d_ready_out}, bus.lc_addr_out); end
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    total++; if ({bus.l1d_ready_out, bus.lc_valid_out} !== 2'b10) begin bad++; $display("[TB] FAIL reaccept_ready got=%b want=10", {bus.l1d_ready_out, bus.lc_valid_out}); end
    tick();
    bus.l1d_valid_in = 1'b0;
    total++; if (bus.lc_valid_out !== 1'b1 || bus.lc_addr_out !== 64'h7000) begin bad++; $display("[TB] FAIL reaccept_send got=%0b/%h want=1/7000", bus.lc_valid_out, bus.lc_addr_out); end
    bus.lc_ready_in = 1'b1;
    tick();
    bus.lc_ready_in = 1'b0;
    bus.lc_valid_in = 1'b1; bus.lc_addr_in = 64'h7000; bus.l1d_resp_ready_in = 1'b1;
    tick();
    bus.lc_valid_in = 1'b0;
    total++; if ({bus.l1d_resp_valid_out, err_out} !== 2'b10) begin bad++; $display("[TB] FAIL reaccept_fill got=%b want=10", {bus.l1d_resp_valid_out, err_out}); end
    tick();
    bus.lc_valid_in = 1'b1;
    tick();
    bus.lc_valid_in = 1'b0;
    total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL stale_entry_discarded got=%0b want=1", err_out); end
    idle_inputs();
  endtask

  task automatic test_random(input int cycles);
    int                   q[$];
    bit                   busy, m_we, r_full, full, ei, ed;
    int                   last, gnt, r_src;
    logic [63:0]          m_addr, r_addr;
    logic [LINE_BITS-1:0] m_value, r_value;
    reset_dut();
    busy = 1'b0; last = 1; r_full = 1'b0; r_src = 0;
    m_we = 1'b0; m_addr = '0; m_value = '0; r_addr = '0; r_value = '0;
    for (int c = 0; c < cycles; c++) begin
      bus.l1i_valid_in      = ($urandom_range(0, 2) != 0);
      bus.l1i_addr_in       = {$urandom, $urandom};
      bus.l1d_valid_in      = ($urandom_range(0, 2) != 0);
      bus.l1d_we_in         = ($urandom_range(0, 3) == 0);
      bus.l1d_addr_in       = {$urandom, $urandom};
      bus.l1d_value_in      = rand_line();
      bus.lc_ready_in       = ($urandom_range(0, 1) == 1);
      bus.lc_valid_in       = (q.size() > 0) && ($urandom_range(0, 3) == 0);
      bus.lc_addr_in        = {$urandom, $urandom};
      bus.lc_value_in       = rand_line();
      bus.l1i_resp_ready_in = ($urandom_range(0, 1) == 1);
      bus.l1d_resp_ready_in = ($urandom_range(0, 1) == 1);
      #1;
      full = (q.size() == MAX_OUTSTANDING);
      ei   = !busy && bus.l1i_valid_in && !full;
      ed   = !busy && bus.l1d_valid_in && (bus.l1d_we_in || !full);
      gnt  = -1;
      if (ei && ed)  gnt = (last == 1) ? 0 : 1;
      else if (ei)   gnt = 0;
      else if (ed)   gnt = 1;
      total++; if ({bus.l1i_ready_out, bus.l1d_ready_out} !== {gnt == 0, gnt == 1}) begin bad++; $display("[TB] FAIL rand_ready c=%0d got=%b want=%b", c, {bus.l1i_ready_out, bus.l1d_ready_out}, {gnt == 0, gnt == 1}); end
      total++; if (bus.lc_valid_out !== busy) begin bad++; $display("[TB] FAIL rand_lc_valid c=%0d got=%0b want=%0b", c, bus.lc_valid_out, busy); end
      if (busy) begin
        total++; if (bus.lc_addr_out !== m_addr || bus.lc_we_out !== m_we || bus.lc_value_out !== m_value) begin bad++; $display("[TB] FAIL rand_lc_fields c=%0d got=%h/%0b want=%h/%0b", c, bus.lc_addr_out, bus.lc_we_out, m_addr, m_we); end
      end
      total++; if ({bus.lc_ready_out, bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, err_out} !== {!r_full, r_full && r_src == 0, r_full && r_src == 1, 1'b0}) begin bad++; $display("[TB] FAIL rand_resp_flags c=%0d got=%b want=%b", c, {bus.lc_ready_out, bus.l1i_resp_valid_out, bus.l1d_resp_valid_out, err_out}, {!r_full, r_full && r_src == 0, r_full && r_src == 1, 1'b0}); end
      if (r_full) begin
        total++; if ((r_src == 0 ? bus.l1i_resp_addr_out : bus.l1d_resp_addr_out) !== r_addr || (r_src == 0 ? bus.l1i_resp_value_out : bus.l1d_resp_value_out) !== r_value) begin bad++; $display("[TB] FAIL rand_resp_data c=%0d src=%0d want addr=%h", c, r_src, r_addr); end
      end
      if (r_full && ((r_src == 0) ? bus.l1i_resp_ready_in : bus.l1d_resp_ready_in)) begin
        r_full = 1'b0;
        void'(q.pop_front());
      end else if (!r_full && bus.lc_valid_in) begin
        r_full = 1'b1; r_src = q[0]; r_addr = bus.lc_addr_in; r_value = bus.lc_value_in;
      end
      if (busy) begin
        if (bus.lc_ready_in) busy = 1'b0;
      end else if (gnt >= 0) begin
        busy = 1'b1;
        last = gnt;
        if (gnt == 0) begin
          m_addr = bus.l1i_addr_in & ~64'h3F; m_we = 1'b0; m_value = '0;
          q.push_back(0);
        end else begin
          m_addr = bus.l1d_addr_in & ~64'h3F; m_we = bus.l1d_we_in; m_value = bus.l1d_value_in;
          if (!m_we) q.push_back(1);
        end
      end
      @(posedge clk_in);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_in = 1'b1;
    idle_inputs();
    test_reset();
    test_tie_round_robin();
    test_align();
    test_tracker_full();
    test_response_routing();
    test_orphan_response();
    test_reset_mid_send();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lc_arbiter.md
LC_ARBITER -- requirements
Module: lc_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of in-flight reads awaiting a lower-cache response.
REQ-002 SHALL have parameter LINE_BITS, default 512, meaning the cache-line payload width.
REQ-003 SHALL have ports:
- clk_in  in  1  sole clock; one clock, all state on its rising edge.
- rst_in  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have the L1I request ports:
- l1i_valid_in  in  1  L1I miss (read) request.
- l1i_addr_in  in  64  L1I request address.
- l1i_ready_out  out  1  arbiter accepts the L1I request.
REQ-005 SHALL have the L1D request ports:
- l1d_valid_in  in  1  L1D request.
- l1d_addr_in  in  64  L1D request address.
- l1d_value_in  in  LINE_BITS  writeback line.
- l1d_we_in  in  1  1 = writeback, 0 = read.
- l1d_ready_out  out  1  arbiter accepts the L1D request.
REQ-006 SHALL have the response ports toward L1I and L1D:
- l1i_resp_valid_out, l1d_resp_valid_out  out  1  fill valid.
- l1i_resp_addr_out, l1d_resp_addr_out  out  64  fill address.
- l1i_resp_value_out, l1d_resp_value_out  out  LINE_BITS  fill data.
- l1i_resp_ready_in, l1d_resp_ready_in  in  1  L1 accepts the fill.
REQ-007 SHALL have the lower-cache request ports:
- lc_valid_out  out  1  request to the lower cache.
- lc_addr_out  out  64  request address.
- lc_value_out  out  LINE_BITS  writeback line.
- lc_we_out  out  1  1 = writeback.
- lc_ready_in  in  1  lower cache accepts the request.
REQ-008 SHALL have the lower-cache response ports:
- lc_valid_in  in  1  response valid.
- lc_addr_in  in  64  response address.
- lc_value_in  in  LINE_BITS  response data.
- lc_ready_out  out  1  arbiter accepts the response.
REQ-009 SHALL have port err_out  out  1, a sticky protocol-error flag.

Function
REQ-010 Request FSM SHALL have two states: IDLE and SEND.
REQ-011 In IDLE, the arbiter SHALL assert ready_out combinationally to exactly one eligible requester.
- A requester is eligible when its valid is high and it is not a read while the tracker is full.
- l1d writebacks SHALL always be eligible.
REQ-012 When both requesters are eligible, the arbiter SHALL grant round-robin, picking the source not granted last.
- last_grant SHALL update only on an accepted request.
REQ-013 On accept, the arbiter SHALL register the request with addr[5:0] forced to 0 and the FSM SHALL move to SEND.
- lc_we_out SHALL be 0 and lc_value_out SHALL be 0 for L1I requests.
REQ-014 In SEND:
- lc_valid_out SHALL be 1 and the registered fields SHALL stay stable until lc_ready_in.
- On lc_ready_in, the FSM SHALL return to IDLE.
- Both ready_out signals SHALL be 0 in SEND.
REQ-015 Request throughput SHALL be at most one request per 2 cycles; accept-to-lc_valid_out latency SHALL be 1 cycle.
REQ-016 An accepted read SHALL push its source ID into an in-order tracker FIFO of depth MAX_OUTSTANDING; writebacks SHALL NOT push.
REQ-017 lc_ready_out SHALL be 1 when the one-entry response register is empty.
REQ-018 On lc_valid_in & lc_ready_out, the response register SHALL capture addr/value and route to the tracker head's source.
- Exactly one resp_valid_out SHALL assert the next cycle.
REQ-019 The response register SHALL hold until the routed L1's resp_ready_in is high.
- On that handshake, the register SHALL empty and the tracker SHALL pop in the same cycle.
REQ-020 A response arriving with the tracker empty SHALL be accepted and dropped, and SHALL set err_out until reset.
REQ-021 A tracker push and pop in the same cycle SHALL leave the count unchanged, including when the tracker is full.
- A full tracker with a simultaneous pop SHALL still block new reads that cycle, because eligibility uses the registered count.
REQ-022 Tracker pointers SHALL wrap modulo MAX_OUTSTANDING; count width SHALL be clog2(MAX_OUTSTANDING+1).

Reset
REQ-023 rst_in SHALL asynchronously apply the following:
- FSM goes to IDLE; tracker is emptied; response register is emptied.
- All valid/ready outputs are 0 while rst_in is high; err_out is 0.
- Data/address outputs are 0.
- last_grant is L1D, so the first tie grants L1I.
REQ-024 Reset mid-SEND or mid-response SHALL discard the in-flight request/response with no handshake completed.

Structure
REQ-025 mem_pkg SHALL hold:
- lc_src_e enum: SRC_L1I=0, SRC_L1D=1.
- LC_LINE_BITS=512.
- LC_OFFSET_BITS=6.
REQ-026 The tracker SHALL be sub-module lc_src_fifo, parameterised by depth, with push/pop/full/empty/head.

Verification
REQ-027 Both valid in IDLE after reset; l1i addr 0x1040, l1d read 0x2000 -> L1I granted first, lc_addr_out=0x1040 next cycle; L1D granted after lc_ready_in.
REQ-028 l1i addr 0x1047 -> lc_addr_out=0x1040, lc_we_out=0.
REQ-029 Four L1D reads outstanding with MAX_OUTSTANDING=4 -> l1i read stalled with l1i_ready_out=0; l1d writeback still accepted; no tracker push.
REQ-030 Reads I then D are issued; two responses 0xA000, 0xB000 are returned -> first goes to l1i_resp_*, second to l1d_resp_*. With l1d_resp_ready_in held low 3 cycles -> lc_ready_out=0 for those cycles.
REQ-031 lc_valid_in with the tracker empty -> response dropped, err_out=1 and remains 1 until rst_in.
REQ-032 rst_in asserted while in SEND -> lc_valid_out drops to 0 asynchronously; after release, the same requester is re-accepted cleanly.
